// File: rtl/ysyx_24100012_pkg.sv
// Shared decode constants for the NPC core: instruction formats, ALU ops, RV32I opcodes.
package ysyx_24100012_pkg;

  localparam logic [2:0] TYPE_R   = 3'd0;
  localparam logic [2:0] TYPE_I   = 3'd1;
  localparam logic [2:0] TYPE_S   = 3'd2;
  localparam logic [2:0] TYPE_B   = 3'd3;
  localparam logic [2:0] TYPE_U   = 3'd4;
  localparam logic [2:0] TYPE_J   = 3'd5;
  localparam logic [2:0] TYPE_ILL = 3'd7;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic logic [3:0] alu_arith(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_24100012_imm_gen.sv
// Combinational sign-extended immediate from the instruction word and its format.
module ysyx_24100012_imm_gen
  import ysyx_24100012_pkg::*;
(
  input  logic [31:7] inst_i,
  input  logic [2:0]  inst_type_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (inst_type_i)
      TYPE_I: imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      TYPE_S: imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      TYPE_B: imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                       inst_i[11:8], 1'b0};
      TYPE_U: imm_o = {inst_i[31:12], 12'b0};
      TYPE_J: imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                       inst_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_24100012_idu.sv
// RV32I decode/issue stage: decodes into a registered output slot, with a
// write-pending scoreboard for RAW stalls and a flush for redirects.
module ysyx_24100012_idu
  import ysyx_24100012_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_SEL      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [31:0]           in_inst,
  output logic [4:0]            rf_raddr1,
  output logic [4:0]            rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] in_a,
  output logic [DATA_WIDTH-1:0] in_b,
  output logic [2:0]            inst_type,
  output logic [N_SEL-1:0]      alu_sel,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [4:0]            out_rd,
  output logic                  out_rd_we,
  output logic                  out_illegal,
  input  logic                  wb_valid,
  input  logic [4:0]            wb_rd,
  input  logic                  flush
);

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [4:0]            rs1, rs2, rd;
  logic [2:0]            dec_type;
  logic [31:0]           dec_imm;
  logic [N_SEL-1:0]      dec_sel;
  logic [DATA_WIDTH-1:0] dec_a, dec_b;
  logic                  dec_ill, dec_we, use1, use2, haz1, haz2, stall, accept;

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, pc_q, imm_q;
  logic [2:0]            type_q;
  logic [N_SEL-1:0]      sel_q;
  logic [4:0]            rd_q;
  logic                  rd_we_q, ill_q;
  logic [31:0]           pending_q, pending_d;

  assign opcode    = in_inst[6:0];
  assign funct3    = in_inst[14:12];
  assign rs1       = in_inst[19:15];
  assign rs2       = in_inst[24:20];
  assign rd        = in_inst[11:7];
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  always_comb begin
    dec_type = TYPE_ILL;
    case (opcode)
      OPC_OP:                        dec_type = TYPE_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: dec_type = TYPE_I;
      OPC_STORE:                     dec_type = TYPE_S;
      OPC_BRANCH:                    dec_type = TYPE_B;
      OPC_LUI, OPC_AUIPC:            dec_type = TYPE_U;
      OPC_JAL:                       dec_type = TYPE_J;
      default:                       dec_type = TYPE_ILL;
    endcase
  end

  ysyx_24100012_imm_gen u_imm_gen (
    .inst_i      (in_inst[31:7]),
    .inst_type_i (dec_type),
    .imm_o       (dec_imm)
  );

  always_comb begin
    dec_a   = rf_rdata1;
    dec_b   = dec_imm;
    dec_sel = ALU_ADD;
    dec_ill = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_b   = rf_rdata2;
        dec_sel = alu_arith(funct3, in_inst[30]);
      end
      OPC_OP_IMM: dec_sel = alu_arith(funct3, (funct3 == 3'b101) && in_inst[30]);
      OPC_LOAD, OPC_STORE: dec_sel = ALU_ADD;
      OPC_BRANCH: begin
        dec_b   = rf_rdata2;
        dec_sel = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
      end
      OPC_LUI: begin
        dec_a   = '0;
        dec_sel = ALU_PASS_B;
      end
      OPC_AUIPC: dec_a = in_pc;
      OPC_JAL, OPC_JALR: begin
        dec_a = in_pc;
        dec_b = DATA_WIDTH'(4);
      end
      default: begin
        dec_a   = '0;
        dec_b   = '0;
        dec_ill = 1'b1;
      end
    endcase
  end

  assign dec_we = (dec_type inside {TYPE_R, TYPE_I, TYPE_U, TYPE_J}) && (rd != 5'd0);
  assign use1   = dec_type inside {TYPE_R, TYPE_I, TYPE_S, TYPE_B};
  assign use2   = dec_type inside {TYPE_R, TYPE_S, TYPE_B};

  // The slot's own destination counts as pending until it is handed over.
  assign haz1 = (rs1 != 5'd0) && (pending_q[rs1] || (valid_q && rd_we_q && rd_q == rs1));
  assign haz2 = (rs2 != 5'd0) && (pending_q[rs2] || (valid_q && rd_we_q && rd_q == rs2));
  assign stall    = (use1 && haz1) || (use2 && haz2);
  assign in_ready = !flush && !stall && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    pending_d = pending_q;
    if (wb_valid) pending_d[wb_rd] = 1'b0;
    if (valid_q && out_ready && rd_we_q) pending_d[rd_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      type_q    <= '0;
      sel_q     <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      ill_q     <= 1'b0;
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
      if (flush)          valid_q <= 1'b0;
      else if (accept)    valid_q <= 1'b1;
      else if (out_ready) valid_q <= 1'b0;
      if (accept) begin
        a_q     <= dec_a;
        b_q     <= dec_b;
        pc_q    <= in_pc;
        imm_q   <= dec_imm;
        type_q  <= dec_type;
        sel_q   <= dec_sel;
        rd_q    <= rd;
        rd_we_q <= dec_we;
        ill_q   <= dec_ill;
      end
    end
  end

  assign out_valid   = valid_q;
  assign in_a        = a_q;
  assign in_b        = b_q;
  assign inst_type   = type_q;
  assign alu_sel     = sel_q;
  assign out_pc      = pc_q;
  assign out_imm     = imm_q;
  assign out_rd      = rd_q;
  assign out_rd_we   = rd_we_q;
  assign out_illegal = ill_q;

endmodule

// File: tb/tb_ysyx_24100012_idu.sv
// Bench for ysyx_24100012_idu: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural decode/scoreboard model.
module tb_ysyx_24100012_idu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, rf_rdata1, rf_rdata2;
  logic [4:0]  rf_raddr1, rf_raddr2, out_rd, wb_rd;
  logic [31:0] in_a, in_b, out_pc, out_imm;
  logic [2:0]  inst_type;
  logic [3:0]  alu_sel;
  logic        out_rd_we, out_illegal, wb_valid, flush;

  always #5 clk = ~clk;

  ysyx_24100012_idu #(.DATA_WIDTH(32), .N_SEL(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .out_valid(out_valid),
    .out_ready(out_ready), .in_a(in_a), .in_b(in_b), .inst_type(inst_type),
    .alu_sel(alu_sel), .out_pc(out_pc), .out_imm(out_imm), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_illegal(out_illegal), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .flush(flush)
  );

  bit [31:0] regs [32];
  always_comb begin
    rf_rdata1 = regs[in_inst[19:15]];
    rf_rdata2 = regs[in_inst[24:20]];
  end

  typedef struct {
    bit [31:0] a, b, pc, imm;
    bit [2:0]  typ;
    bit [3:0]  sel;
    bit [4:0]  rd;
    bit        we, ill, u1, u2, ca, cb;
  } exp_t;

  int unsigned alu_base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  int errors = 0;
  int checks = 0;
  exp_t      ms;
  bit        mvalid;
  bit [31:0] mpend;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model_dec(bit [31:0] i, bit [31:0] pc);
    exp_t e;
    bit [31:0] sx, iI, iS, iB, iU, iJ;
    int unsigned f3;
    f3 = i[14:12];
    sx = {32{i[31]}};
    iI = (sx << 12) | 32'(i[31:20]);
    iS = (sx << 12) | (32'(i[31:25]) << 5) | 32'(i[11:7]);
    iB = (sx << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
    iU = i & 32'hFFFF_F000;
    iJ = (sx << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
    e = '{a: regs[i[19:15]], b: 0, pc: pc, imm: 0, typ: 0, sel: 0, rd: i[11:7],
          we: 0, ill: 0, u1: 0, u2: 0, ca: 1, cb: 1};
    case (i[6:0])
      7'h33: begin
        e.typ = 0; e.b = regs[i[24:20]];
        e.sel = 4'(alu_base[f3]);
        if (i[30] && f3 == 0) e.sel = 1;
        if (i[30] && f3 == 5) e.sel = 7;
      end
      7'h13: begin
        e.typ = 1; e.b = iI; e.imm = iI;
        e.sel = 4'(alu_base[f3]);
        if (i[30] && f3 == 5) e.sel = 7;
      end
      7'h03: begin e.typ = 1; e.b = iI; e.imm = iI; end
      7'h23: begin e.typ = 2; e.b = iS; e.imm = iS; end
      7'h63: begin
        e.typ = 3; e.b = regs[i[24:20]]; e.imm = iB;
        e.sel = (f3 >= 6) ? 4 : (f3 >= 4) ? 3 : 1;
      end
      7'h37: begin e.typ = 4; e.b = iU; e.imm = iU; e.sel = 10; e.ca = 0; end
      7'h17: begin e.typ = 4; e.a = pc; e.b = iU; e.imm = iU; end
      7'h6f: begin e.typ = 5; e.a = pc; e.b = 4; e.imm = iJ; end
      7'h67: begin e.typ = 1; e.a = pc; e.b = 4; e.imm = iI; end
      default: begin e.typ = 7; e.ill = 1; e.ca = 0; e.cb = 0; end
    endcase
    e.we = (e.typ inside {0, 1, 4, 5}) && e.rd != 0;
    e.u1 = e.typ inside {0, 1, 2, 3};
    e.u2 = e.typ inside {0, 2, 3};
    return e;
  endfunction

  function automatic bit hazard(bit [4:0] r);
    return r != 0 && (mpend[r] || (mvalid && ms.we && ms.rd == r));
  endfunction

  function automatic bit model_ready();
    exp_t d;
    d = model_dec(in_inst, in_pc);
    return !flush && !((d.u1 && hazard(in_inst[19:15])) || (d.u2 && hazard(in_inst[24:20])))
           && (!mvalid || out_ready);
  endfunction

  task automatic drive(input bit v, input bit [31:0] inst, input bit [31:0] pc,
                       input bit ordy, input bit fl, input bit wv, input bit [4:0] wr);
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy;
    flush = fl; wb_valid = wv; wb_rd = wr;
  endtask

  // Called at a falling edge with inputs applied; checks, advances the model, returns at the next falling edge.
  task automatic tick();
    exp_t d;
    bit   er;
    #1;
    d  = model_dec(in_inst, in_pc);
    er = model_ready();
    chk("in_ready", in_ready, er);
    chk("rf_raddr", {rf_raddr1, rf_raddr2}, {in_inst[19:15], in_inst[24:20]});
    chk("out_valid", out_valid, mvalid);
    if (mvalid) begin
      if (ms.ca) chk("in_a", in_a, ms.a);
      if (ms.cb) chk("in_b", in_b, ms.b);
      chk("inst_type", inst_type, ms.typ);
      chk("alu_sel", alu_sel, ms.sel);
      chk("out_pc", out_pc, ms.pc);
      chk("out_imm", out_imm, ms.imm);
      chk("out_rd", out_rd, ms.rd);
      chk("out_rd_we", out_rd_we, ms.we);
      chk("out_illegal", out_illegal, ms.ill);
    end
    if (wb_valid) mpend[wb_rd] = 1'b0;
    if (mvalid && out_ready && ms.we) mpend[ms.rd] = 1'b1;
    if (flush) mvalid = 0;
    else if (in_valid && er) begin ms = d; mvalid = 1; end
    else if (out_ready) mvalid = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit [31:0] rand_inst();
    bit [6:0] opcs [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h7f};
    bit [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 15) != 0) w[6:0] = opcs[$urandom_range(0, 9)];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    mvalid = 0; mpend = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_inst_type", inst_type, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_illegal", out_illegal, 0);
    chk("rst_rd_we", out_rd_we, 0);
    rst = 1'b0;
    @(negedge clk);

    // addi x1,x0,5
    drive(1, 32'h0050_0093, 32'h8000_0000, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("addi_valid", out_valid, 1);
    chk("addi_a", in_a, 0);
    chk("addi_b", in_b, 5);
    chk("addi_sel", alu_sel, 0);
    chk("addi_type", inst_type, 1);
    chk("addi_rd", out_rd, 1);
    chk("addi_we", out_rd_we, 1);
    chk("addi_pc", out_pc, 32'h8000_0000);
    tick();

    // add x2,x1,x1 behind it: stalls until the cycle after wb of x1
    drive(1, 32'h0010_8133, 32'h8000_0004, 1, 0, 0, 0);
    #1 chk("raw_slot", in_ready, 0);
    tick();
    #1 chk("raw_pend", in_ready, 0);
    tick();
    tick();
    drive(1, 32'h0010_8133, 32'h8000_0004, 1, 0, 1, 1);
    #1 chk("raw_wb_cycle", in_ready, 0);
    tick();
    drive(1, 32'h0010_8133, 32'h8000_0004, 1, 0, 0, 0);
    #1 chk("raw_release", in_ready, 1);
    tick();
    #1;
    chk("raw_issued_rd", out_rd, 2);
    chk("raw_issued_a", in_a, regs[1]);

    // backpressure: addi x3,x0,7 waits behind add x2
    drive(1, 32'h0070_0193, 32'h8000_0008, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", in_ready, 0);
      chk("bp_hold", out_rd, 2);
      tick();
    end
    drive(1, 32'h0070_0193, 32'h8000_0008, 1, 0, 0, 0);
    #1 chk("bp_release", in_ready, 1);
    tick();
    drive(0, 0, 0, 1, 0, 0, 0);
    #1;
    chk("bp_next_rd", out_rd, 3);
    chk("bp_next_b", in_b, 7);
    tick();
    #1 chk("bp_no_dup", out_valid, 0);
    drive(0, 0, 0, 1, 0, 1, 2);
    tick();
    drive(0, 0, 0, 1, 0, 1, 3);
    tick();

    // bne x3,x4,8 then add x9,x8,x0 (branch rd field is x8 but never written)
    drive(1, 32'h0041_9463, 32'h100, 0, 0, 0, 0);
    #1 chk("br_ready", in_ready, 1);
    tick();
    drive(1, 32'h0004_04B3, 32'h104, 1, 0, 0, 0);
    #1;
    chk("br_sel", alu_sel, 1);
    chk("br_type", inst_type, 3);
    chk("br_imm", out_imm, 8);
    chk("br_we", out_rd_we, 0);
    chk("br_no_sb", in_ready, 1);
    tick();

    // flush with a held slot and a pending input
    drive(1, 32'h00A0_0513, 32'h108, 0, 1, 0, 0);
    #1 chk("flush_ready", in_ready, 0);
    tick();
    drive(1, 32'h0004_85B3, 32'h10C, 1, 0, 0, 0);
    #1;
    chk("flush_valid", out_valid, 0);
    chk("flush_pend", in_ready, 1);
    tick();

    // same-cycle set and clear of x5
    drive(1, 32'h0010_0293, 32'h110, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0, 1, 5);
    tick();
    drive(1, 32'h0002_8333, 32'h114, 1, 0, 0, 0);
    #1 chk("setclr_x5", in_ready, 0);
    tick();

    // asynchronous reset while stalled
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_pend", in_ready, 1);
    mvalid = 0; mpend = '0;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    // illegal opcode still issues
    drive(1, 32'h0000_007F, 32'h200, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0, 0, 0);
    #1;
    chk("ill_flag", out_illegal, 1);
    chk("ill_type", inst_type, 7);
    chk("ill_sel", alu_sel, 0);
    chk("ill_we", out_rd_we, 0);
    tick();

    for (int c = 0; c < 3000; c++) begin
      bit [4:0] plist [$];
      bit [4:0] wr;
      bit       wv;
      for (int r = 1; r < 32; r++) if (mpend[r]) plist.push_back(5'(r));
      wv = 0; wr = 5'($urandom_range(0, 31));
      if (plist.size() > 0 && $urandom_range(0, 1) == 1) begin
        wv = 1; wr = plist[$urandom_range(0, plist.size() - 1)];
      end else if ($urandom_range(0, 7) == 0) wv = 1;
      if ($urandom_range(0, 31) == 0) regs[$urandom_range(1, 31)] = $urandom;
      drive($urandom_range(0, 3) != 0, rand_inst(), $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, wv, wr);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24100012_idu.md
# ysyx_24100012_idu

Instruction decode / issue stage for the NPC core, directly upstream of the ALU. It accepts fetched instructions over a valid/ready handshake and decodes RV32I. It reads operands from the register file, builds `in_a`/`in_b`/`inst_type`/`alu_sel` for the ALU, and holds them in a registered output slot. A 32-entry write-pending scoreboard stalls on RAW hazards, and a flush input discards the in-flight instruction on redirect.

## Interface
- `DATA_WIDTH`, 32, operand width; only 32 (RV32I) is supported.
- `N_SEL`, 4, width of `alu_sel`.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: the IFU offers `in_pc`/`in_inst`.
- `in_ready` out 1: the IDU accepts this cycle.
- `in_pc` in DATA_WIDTH: PC of the offered instruction.
- `in_inst` in 32: the offered instruction word.
- `rf_raddr1`, `rf_raddr2` out 5: combinational `in_inst[19:15]` and `in_inst[24:20]`.
- `rf_rdata1`, `rf_rdata2` in DATA_WIDTH: same-cycle register file read data.
- `out_valid` out 1: the output slot holds a decoded instruction.
- `out_ready` in 1: the ALU/EXU consumes the slot.
- `in_a`, `in_b` out DATA_WIDTH: ALU operands.
- `inst_type` out 3: instruction format.
- `alu_sel` out N_SEL: ALU operation.
- `out_pc`, `out_imm` out DATA_WIDTH: PC and sign-extended immediate.
- `out_rd` out 5, `out_rd_we` out 1: destination register and its write enable.
- `out_illegal` out 1: undecodable opcode.
- `wb_valid` in 1, `wb_rd` in 5: writeback retires a write to `wb_rd`.
- `flush` in 1: redirect; discard the slot and the current input.

## Operation
- `inst_type` encoding:
  - R=0, I=1, S=2, B=3, U=4, J=5, ILLEGAL=7.
- `alu_sel` encoding:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10.
- Operand selection:
  - OP: `in_a`=rs1, `in_b`=rs2, `alu_sel` from funct3/funct7[5].
  - OP-IMM: `in_a`=rs1, `in_b`=imm. SRAI is selected by `inst[30]`.
  - LOAD/STORE: rs1 + imm (ADD).
  - BRANCH: rs1, rs2. BEQ/BNE use SUB; BLT/BGE use SLT; BLTU/BGEU use SLTU.
  - LUI: `in_b`=imm, PASS_B.
  - AUIPC: `in_a`=pc, `in_b`=imm, ADD.
  - JAL/JALR: `in_a`=pc, `in_b`=4, ADD. JALR still reads rs1 for the target.
- `out_rd_we`:
  - 1 for R, I (OP-IMM, LOAD, JALR), U and J.
  - Forced to 0 when rd=0.
- Illegal opcodes:
  - `out_illegal`=1, `inst_type`=7, `alu_sel`=ADD, `out_rd_we`=0.
  - The instruction still issues.
- Source usage:
  - rs1 is used by R, I, S and B.
  - rs2 is used by R, S and B.
  - Reads of x0 never stall.
- Scoreboard:
  - 32-bit `pending` vector.
  - Bit `out_rd` is set on the output handshake (`out_valid && out_ready && out_rd_we`).
  - Bit `wb_rd` is cleared on `wb_valid`.
  - If set and clear hit the same register in the same cycle, set wins.
- Stall condition: any used rs matches either
  - a `pending` bit, or
  - `out_rd` while `out_valid && out_rd_we`.
- Flush:
  - `out_valid` goes to 0 next cycle.
  - `in_ready`=0 during the flush cycle, so no capture.
  - `pending` is untouched; handed-over instructions still write back.

## Timing
- `in_ready` = `!flush && !stall && (!out_valid || out_ready)`.
- An input is accepted on `in_valid && in_ready`. The output slot is loaded at that edge, so latency is 1 cycle.
- Throughput is 1 instruction/cycle with no hazards: accept and drain in the same cycle.
- Output behaviour:
  - Outputs are stable while `out_valid && !out_ready`.
  - `out_valid` drops after a drain unless a new instruction loads in the same cycle.
- Scoreboard timing:
  - A `pending` clear is visible the cycle after `wb_valid`; there is no bypass.
  - Stall lifts one cycle after writeback.
- Reset values: `out_valid`=0, `pending`=0, and all slot registers 0 (`inst_type`=0, `alu_sel`=0, `out_illegal`=0).
- Reset mid-handshake abandons the slot.
- Flush takes priority over capture and stall. A drain coinciding with flush completes, and its scoreboard set still occurs.

## Structure
- Shared package `ysyx_24100012_pkg` holds:
  - `inst_type` and `alu_sel` localparams;
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR);
  - the ALU consumes the same `alu_sel` constants.
- Sub-module: `ysyx_24100012_imm_gen`, a combinational immediate generator from the instruction and `inst_type`.
- The decoder, scoreboard and output slot live in the top module.

## Test plan
- ADD: `addi x1,x0,5` (0x00500093), pc=0x80000000.
  - Next cycle: `in_a`=0, `in_b`=5, `alu_sel`=ADD, `inst_type`=I, `out_rd`=1, `out_rd_we`=1.
- RAW stall:
  - Issue `addi x1,x0,5`, drain it, then offer `add x2,x1,x1`.
  - `in_ready`=0 until the cycle after `wb_valid=1`, `wb_rd=1`; then it is accepted.
- Backpressure: `out_ready`=0 for 3 cycles with `in_valid`=1.
  - Slot holds; `in_ready`=0; no instruction is lost or duplicated.
- Branch: `bne x3,x4,8`.
  - `alu_sel`=SUB, `inst_type`=B, `out_imm`=8, `out_rd_we`=0, no scoreboard set.
- Flush: `flush`=1 with `out_valid`=1 and `in_valid`=1.
  - Next cycle `out_valid`=0; the input was not accepted; `pending` is unchanged.
- Corner cases:
  - Same-cycle set and clear of x5 leaves x5 pending.
  - Illegal opcode 0x0000007F issues with `out_illegal`=1.
  - Async `rst` mid-stall clears `out_valid` and `pending` immediately.
